// File: rtl/p_mul_seq_pkg.sv
// Shared constants and lane lookups for the sequential packed multiplier.
// Lane geometry is derived from the one-hot pack width so every block agrees on it.
package p_mul_seq_pkg;

   localparam int PW_32 = 0;
   localparam int PW_16 = 1;
   localparam int PW_8  = 2;
   localparam int PW_4  = 3;
   localparam int PW_2  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic pw_valid(input logic [4:0] pw);
      return $onehot(pw);
   endfunction

   // Value of the iteration counter on the final RUN cycle (w-1).
   function automatic logic [4:0] term_count(input logic [4:0] pw);
      logic [4:0] tc;
      tc = 5'd0;
      case (pw)
         5'b00001: tc = 5'd31;
         5'b00010: tc = 5'd15;
         5'b00100: tc = 5'd7;
         5'b01000: tc = 5'd3;
         5'b10000: tc = 5'd1;
         default:  tc = 5'd0;
      endcase
      return tc;
   endfunction

   // Bit-index mask that maps any bit position to the LSB position of its lane.
   function automatic logic [4:0] lane_base_mask(input logic [4:0] pw);
      logic [4:0] m;
      m = 5'b00000;
      case (pw)
         5'b00010: m = 5'b10000;
         5'b00100: m = 5'b11000;
         5'b01000: m = 5'b11100;
         5'b10000: m = 5'b11110;
         default:  m = 5'b00000;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] lane_lsb_mask(input logic [4:0] pw);
      logic [31:0] m;
      m = 32'h0000_0001;
      case (pw)
         5'b00010: m = 32'h0001_0001;
         5'b00100: m = 32'h0101_0101;
         5'b01000: m = 32'h1111_1111;
         5'b10000: m = 32'h5555_5555;
         default:  m = 32'h0000_0001;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] lane_msb_mask(input logic [4:0] pw);
      logic [31:0] m;
      m = 32'h8000_0000;
      case (pw)
         5'b00010: m = 32'h8000_8000;
         5'b00100: m = 32'h8080_8080;
         5'b01000: m = 32'h8888_8888;
         5'b10000: m = 32'hAAAA_AAAA;
         default:  m = 32'h8000_0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/p_mul_seq_if.sv
// Request/response bus of the sequential packed multiplier.
interface p_mul_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] lhs;
   logic [31:0] rhs;
   logic [4:0]  pw;
   logic        clmul;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] result;

   modport master (
      output req_valid, lhs, rhs, pw, clmul, rsp_ready,
      input  req_ready, rsp_valid, result
   );

   modport slave (
      input  req_valid, lhs, rhs, pw, clmul, rsp_ready,
      output req_ready, rsp_valid, result
   );
endinterface

// File: rtl/p_addsub.sv
// Packed adder/subtractor: carries are restarted at every lane LSB, so no
// carry or borrow ever crosses a lane boundary.
module p_addsub
   import p_mul_seq_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  pw,
   input  logic        sub,
   output logic [31:0] y
);

   logic [4:0] base;
   logic       carry;
   logic       bi;

   // Ripple per bit; a lane start reloads the carry with the subtract carry-in.
   always_comb begin
      base  = lane_base_mask(pw);
      carry = 1'b0;
      bi    = 1'b0;
      y     = '0;
      for (int i = 0; i < 32; i++) begin
         if ((5'(i) & ~base) == 5'd0)
            carry = sub;
         bi    = b[i] ^ sub;
         y[i]  = a[i] ^ bi ^ carry;
         carry = (a[i] & bi) | (carry & (a[i] ^ bi));
      end
   end

endmodule

// File: rtl/p_mul_seq.sv
// Multi-cycle packed multiplier: one shift-and-add step per cycle across all lanes,
// integer (via p_addsub) or carry-less (XOR) accumulation, request/response handshake.
module p_mul_seq
   import p_mul_seq_pkg::*;
(
   input  logic         clock,
   input  logic         resetn,
   input  logic         flush,
   p_mul_seq_if.slave   bus
);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] acc;
   logic [31:0] lhs_sh;
   logic [31:0] rhs_sh;
   logic [4:0]  count;
   logic [4:0]  pw_q;
   logic        clmul_q;

   logic        accept;
   logic        last;
   logic [4:0]  base;
   logic [31:0] gate;
   logic [31:0] gated;
   logic [31:0] sum;
   logic [31:0] acc_nxt;

   assign bus.req_ready = (state == IDLE) && resetn;
   assign bus.rsp_valid = (state == DONE);
   assign bus.result    = (state == DONE) ? acc : 32'd0;

   assign accept = bus.req_valid && bus.req_ready;
   assign last   = (count == term_count(pw_q));
   assign base   = lane_base_mask(pw_q);

   // Broadcast each lane's multiplier LSB over the whole lane to gate the multiplicand.
   always_comb begin
      gate = '0;
      for (int i = 0; i < 32; i++)
         gate[i] = rhs_sh[5'(i) & base];
   end

   assign gated   = lhs_sh & gate;
   assign acc_nxt = clmul_q ? (acc ^ gated) : sum;

   p_addsub u_addsub (
      .a   (acc),
      .b   (gated),
      .pw  (pw_q),
      .sub (1'b0),
      .y   (sum)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Flush overrides every transition, including an accept or a DONE handshake.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (accept) state_nxt = pw_valid(bus.pw) ? RUN : DONE;
            RUN:  if (last) state_nxt = DONE;
            DONE: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         acc     <= '0;
         lhs_sh  <= '0;
         rhs_sh  <= '0;
         count   <= '0;
         pw_q    <= '0;
         clmul_q <= 1'b0;
      end else if (flush) begin
         acc   <= '0;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lhs_sh  <= bus.lhs;
                  rhs_sh  <= bus.rhs;
                  pw_q    <= bus.pw;
                  clmul_q <= bus.clmul;
                  acc     <= '0;
                  count   <= '0;
               end
            end
            RUN: begin
               acc    <= acc_nxt;
               lhs_sh <= (lhs_sh << 1) & ~lane_lsb_mask(pw_q);
               rhs_sh <= (rhs_sh >> 1) & ~lane_msb_mask(pw_q);
               count  <= count + 5'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_p_mul_seq.sv
// Directed testbench for p_mul_seq: hand-computed packed products, latency,
// backpressure, reset/flush abort and flush priority.
module tb_p_mul_seq;

   logic clock;
   logic resetn;
   logic flush;
   int   checks;
   int   errors;

   p_mul_seq_if bus();

   p_mul_seq dut (
      .clock  (clock),
      .resetn (resetn),
      .flush  (flush),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drives one request, waits (bounded) for the response and completes the handshake.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] p,
                        input logic c, output logic [31:0] res, output int lat);
      @(negedge clock);
      bus.lhs       = a;
      bus.rhs       = b;
      bus.pw        = p;
      bus.clmul     = c;
      bus.req_valid = 1'b1;
      bus.rsp_ready = 1'b0;
      @(posedge clock);
      lat = 999;
      res = 'x;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clock);
         bus.req_valid = 1'b0;
         if (bus.rsp_valid) begin
            lat = n;
            res = bus.result;
            break;
         end
      end
      if (lat != 999) begin
         bus.rsp_ready = 1'b1;
         @(negedge clock);
         bus.rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.result !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got rdy=%b vld=%b res=%h want 0 0 00000000",
                  bus.req_ready, bus.rsp_valid, bus.result);
      end
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_idle_ready got %b want 1", bus.req_ready);
      end
   endtask

   task automatic test_products();
      logic [31:0] res;
      int          lat;

      do_op(32'h0000_0003, 32'h0000_0005, 5'b00001, 1'b0, res, lat);
      checks += 2;
      if (res !== 32'h0000_000F) begin errors++; $display("[TB] FAIL int32_result got %h want 0000000f", res); end
      if (lat !== 33) begin errors++; $display("[TB] FAIL int32_latency got %0d want 33", lat); end

      do_op(32'hFF02_1003, 32'h0203_1005, 5'b00100, 1'b0, res, lat);
      checks += 2;
      if (res !== 32'hFE06_000F) begin errors++; $display("[TB] FAIL int8_result got %h want fe06000f", res); end
      if (lat !== 9) begin errors++; $display("[TB] FAIL int8_latency got %0d want 9", lat); end

      do_op(32'h0003_0003, 32'h0003_0003, 5'b00010, 1'b1, res, lat);
      checks += 2;
      if (res !== 32'h0005_0005) begin errors++; $display("[TB] FAIL clmul16_result got %h want 00050005", res); end
      if (lat !== 17) begin errors++; $display("[TB] FAIL clmul16_latency got %0d want 17", lat); end

      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 1'b0, res, lat);
      checks += 2;
      if (res !== 32'h5555_5555) begin errors++; $display("[TB] FAIL int2_result got %h want 55555555", res); end
      if (lat !== 3) begin errors++; $display("[TB] FAIL int2_latency got %0d want 3", lat); end

      do_op(32'h1234_5678, 32'h0000_0007, 5'b00011, 1'b0, res, lat);
      checks += 2;
      if (res !== 32'h0000_0000) begin errors++; $display("[TB] FAIL invalid_pw_result got %h want 00000000", res); end
      if (lat !== 1) begin errors++; $display("[TB] FAIL invalid_pw_latency got %0d want 1", lat); end

      // 0x0F clmul 0x0F = 0x55, whereas the integer product would be 0xE1.
      do_op(32'h0000_000F, 32'h0000_000F, 5'b00001, 1'b1, res, lat);
      checks++;
      if (res !== 32'h0000_0055) begin errors++; $display("[TB] FAIL clmul32_result got %h want 00000055", res); end

      do_op(32'h0000_000F, 32'h0000_000F, 5'b00001, 1'b0, res, lat);
      checks++;
      if (res !== 32'h0000_00E1) begin errors++; $display("[TB] FAIL int32_e1_result got %h want 000000e1", res); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      int          lat;
      do_op(32'h1234_5678, 32'h1111_1111, 5'b01000, 1'b0, res, lat);
      checks++;
      if (res !== 32'h1234_5678) begin errors++; $display("[TB] FAIL b2b_int4 got %h want 12345678", res); end
      do_op(32'h00FF_0101, 32'h0003_0003, 5'b00010, 1'b1, res, lat);
      checks++;
      if (res !== 32'h0101_0303) begin errors++; $display("[TB] FAIL b2b_clmul16 got %h want 01010303", res); end
   endtask

   task automatic test_backpressure();
      bit seen;
      @(negedge clock);
      bus.lhs = 32'h0000_0003; bus.rhs = 32'h0000_0005; bus.pw = 5'b00100; bus.clmul = 1'b0;
      bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      bus.req_valid = 1'b0;
      bus.lhs = 32'hFFFF_FFFF; bus.rhs = 32'hFFFF_FFFF; bus.pw = 5'b00001; bus.clmul = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 50; n++) begin
         if (bus.rsp_valid) begin seen = 1'b1; break; end
         @(negedge clock);
      end
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL bp_timeout got no rsp_valid want rsp_valid within 50 cycles"); end
      bus.req_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.result !== 32'h0000_000F || bus.req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold_%0d got vld=%b res=%h rdy=%b want 1 0000000f 0",
                     k, bus.rsp_valid, bus.result, bus.req_ready);
         end
         @(negedge clock);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clock);
      bus.rsp_ready = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_release got vld=%b rdy=%b want 0 1", bus.rsp_valid, bus.req_ready);
      end
   endtask

   task automatic test_reset_abort();
      bit seen;
      @(negedge clock);
      bus.lhs = 32'h0000_0003; bus.rhs = 32'h0000_0005; bus.pw = 5'b00001; bus.clmul = 1'b0;
      bus.req_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.req_valid = 1'b0;
      repeat (9) @(negedge clock);
      resetn = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.result !== 32'd0) begin
         errors++;
         $display("[TB] FAIL abort_reset_outputs got rdy=%b vld=%b res=%h want 0 0 00000000",
                  bus.req_ready, bus.rsp_valid, bus.result);
      end
      @(negedge clock);
      resetn = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_reset_idle got rdy=%b want 1", bus.req_ready); end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (bus.rsp_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("[TB] FAIL abort_reset_no_rsp got rsp_valid=1 want 0"); end
   endtask

   task automatic test_flush();
      bit          seen;
      logic [31:0] res;
      int          lat;
      @(negedge clock);
      bus.lhs = 32'h0000_0003; bus.rhs = 32'h0000_0005; bus.pw = 5'b00001; bus.clmul = 1'b0;
      bus.req_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_idle got rdy=%b vld=%b want 1 0", bus.req_ready, bus.rsp_valid);
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (bus.rsp_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("[TB] FAIL flush_no_rsp got rsp_valid=1 want 0"); end
      do_op(32'h0000_0003, 32'h0000_0005, 5'b00100, 1'b0, res, lat);
      checks++;
      if (res !== 32'h0000_000F) begin errors++; $display("[TB] FAIL flush_next_result got %h want 0000000f", res); end
   endtask

   task automatic test_flush_priority();
      @(negedge clock);
      bus.lhs = 32'h0000_0003; bus.rhs = 32'h0000_0005; bus.pw = 5'b00100; bus.clmul = 1'b0;
      bus.req_valid = 1'b1;
      flush = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL flushprio_ready got %b want 1", bus.req_ready); end
      @(negedge clock);
      bus.req_valid = 1'b0;
      flush = 1'b0;
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flushprio_dropped got rdy=%b vld=%b want 1 0", bus.req_ready, bus.rsp_valid);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      resetn = 1'b0;
      flush  = 1'b0;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.lhs   = '0;
      bus.rhs   = '0;
      bus.pw    = '0;
      bus.clmul = 1'b0;
      test_reset();
      test_products();
      test_back_to_back();
      test_backpressure();
      test_reset_abort();
      test_flush();
      test_flush_priority();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/p_mul_seq.md
Name: p_mul_seq

Overview:
- Multi-cycle packed multiplier for the packed-arithmetic datapath.
- Takes lhs/rhs plus a one-hot pack width, computes per-lane products by iterative shift-and-add, and returns one packed result through a request/response handshake.
- Accumulation uses the existing packed adder, so carries never cross lane boundaries.
- Supports integer (low half, mod 2^w) and carry-less (XOR accumulate) modes.

Parameters:
- none (datapath fixed at 32 bits; lane widths 32/16/8/4/2 selected by pw)

Ports:
- clock    in   1   system clock, all state on rising edge
- resetn   in   1   asynchronous, active-low reset
- flush    in   1   synchronous abort of any in-flight operation
- req_valid  in  1   request valid
- req_ready  out 1   request accepted when req_valid & req_ready
- lhs      in   32  packed multiplicand
- rhs      in   32  packed multiplier
- pw       in   5   one-hot pack width: [0]=32, [1]=16, [2]=8, [3]=4, [4]=2
- clmul    in   1   1 = carry-less (XOR) accumulate, 0 = integer add
- rsp_valid  out 1   result valid
- rsp_ready  in  1   consumer accepts result when rsp_valid & rsp_ready
- result   out  32  packed product, low w bits per lane

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE. All registers (acc, lhs_sh, rhs_sh, count, captured pw/clmul) = 0. Outputs: req_ready=0 while resetn=0, rsp_valid=0, result=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid & req_ready: capture lhs→lhs_sh, rhs→rhs_sh, pw, clmul; acc=0; count=0.
  - If pw is one-hot, go to RUN; otherwise go to DONE with acc=0.
- RUN (req_ready=0, rsp_valid=0), each cycle, per lane:
  - if the LSB of the rhs_sh lane is 1: acc lane = acc lane + lhs_sh lane (mod 2^w), or acc lane ^ lhs_sh lane when clmul=1; otherwise acc is unchanged.
  - lhs_sh lane <<= 1 with zero-fill at lane LSB; rhs_sh lane >>= 1 with zero-fill at lane MSB. No bits cross lane boundaries.
  - count++. When count == w-1, the final accumulate happens and the next state is DONE.
- RUN cycle counts: w = 32/16/8/4/2 gives 32/16/8/4/2 RUN cycles respectively.
- Latency (accept edge to first rsp_valid=1 cycle): w+1 cycles; invalid pw gives 1 cycle.
- DONE:
  - rsp_valid=1, result=acc, req_ready=0.
  - result and rsp_valid are held stable until rsp_ready=1.
  - On the handshake: return to IDLE; the next request may be accepted in the following cycle (no same-cycle accept).
- flush=1 (in any state): next state=IDLE, acc cleared, no response issued. flush has priority over every other transition, including a simultaneous DONE handshake and a simultaneous request accept in IDLE (that request is dropped, req_ready is still 1 in that cycle).
- Inputs lhs/rhs/pw/clmul are sampled only at accept; later changes are ignored.
- Width rule: integer mode returns only the low w bits of each lane product (high bits discarded); clmul mode returns the low w bits of the polynomial product.

Decomposition:
- Shared package: one-hot pw bit-index constants (PW_32..PW_2); lane-width lookup (5'd31/15/7/3/1 terminal counts); state encoding constants (IDLE, RUN, DONE).
- Sub-module: one instance of the existing p_addsub (sub=0) for integer accumulation, fed acc and gated lhs_sh.
- Inline logic: XOR path, per-lane shift masks, FSM.

Test Plan:
- pw=5'b00001, lhs=0x00000003, rhs=0x00000005, clmul=0 -> rsp_valid rises 33 cycles after accept, result=0x0000000F.
- pw=5'b00100, lhs=0xFF021003, rhs=0x02031005, clmul=0 -> result=0xFE06000F (no inter-lane carry from 0xFF*0x02 or 0x10*0x10); latency 9 cycles.
- pw=5'b00010, lhs=0x00030003, rhs=0x00030003, clmul=1 -> result=0x00050005 after 17 cycles.
- pw=5'b10000, lhs=0xFFFFFFFF, rhs=0xFFFFFFFF, clmul=0 -> result=0x55555555 after 3 cycles. Invalid pw=5'b00011 -> result=0x00000000 after 1 cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid=1 and result stable, req_ready=0 throughout. Pulse rsp_ready -> IDLE and req_ready=1 next cycle.
- Abort: resetn=0 at RUN cycle 10 of a pw_32 op -> outputs 0 immediately, IDLE after release, no rsp. flush=1 at RUN cycle 4 -> IDLE next cycle, rsp_valid never asserts, and a following request (pw_8, 0x03*0x05) returns 0x0000000F.
